// File: rtl/core_pkg.sv
// core_pkg: shared register-index types and constants for the integer core
package core_pkg;
    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    localparam reg_idx_t REG_ZERO = 4'd0;
endpackage

// File: rtl/mux16.sv
// mux16: 16:1 data multiplexer
module mux16 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            sel,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    input  logic [DATA_WIDTH-1:0] in4,
    input  logic [DATA_WIDTH-1:0] in5,
    input  logic [DATA_WIDTH-1:0] in6,
    input  logic [DATA_WIDTH-1:0] in7,
    input  logic [DATA_WIDTH-1:0] in8,
    input  logic [DATA_WIDTH-1:0] in9,
    input  logic [DATA_WIDTH-1:0] in10,
    input  logic [DATA_WIDTH-1:0] in11,
    input  logic [DATA_WIDTH-1:0] in12,
    input  logic [DATA_WIDTH-1:0] in13,
    input  logic [DATA_WIDTH-1:0] in14,
    input  logic [DATA_WIDTH-1:0] in15,
    output logic [DATA_WIDTH-1:0] y
);
    logic [DATA_WIDTH-1:0] arr [16];
    assign arr = '{in0, in1, in2, in3, in4, in5, in6, in7,
                   in8, in9, in10, in11, in12, in13, in14, in15};
    assign y = arr[sel];
endmodule

// File: rtl/rf16_sb.sv
// rf16_sb: 16-entry register file with busy scoreboard, two read ports, writeback and issue ports
module rf16_sb
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_IDX_W-1:0]  raddr0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  rbusy0,
    input  logic [REG_IDX_W-1:0]  raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rbusy1,
    input  logic                  we,
    input  logic [REG_IDX_W-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  iss,
    input  logic [REG_IDX_W-1:0]  issue_rd,
    output logic [NUM_REGS-1:0]   busy_vec
);
    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]   busy;
    logic [DATA_WIDTH-1:0] m0, m1;
    logic                  hit0, hit1, wr_ok;

    // issue is checked last so a same-edge issue leaves the bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (we && waddr == reg_idx_t'(i)) begin
                    regs[i] <= wdata;
                    busy[i] <= 1'b0;
                end
                if (iss && issue_rd == reg_idx_t'(i)) busy[i] <= 1'b1;
            end
        end
    end

    assign busy_vec = {busy, 1'b0};

    mux16 #(.DATA_WIDTH(DATA_WIDTH)) u_mux0 (
        .sel(raddr0), .in0('0), .in1(regs[1]), .in2(regs[2]), .in3(regs[3]),
        .in4(regs[4]), .in5(regs[5]), .in6(regs[6]), .in7(regs[7]),
        .in8(regs[8]), .in9(regs[9]), .in10(regs[10]), .in11(regs[11]),
        .in12(regs[12]), .in13(regs[13]), .in14(regs[14]), .in15(regs[15]),
        .y(m0)
    );

    mux16 #(.DATA_WIDTH(DATA_WIDTH)) u_mux1 (
        .sel(raddr1), .in0('0), .in1(regs[1]), .in2(regs[2]), .in3(regs[3]),
        .in4(regs[4]), .in5(regs[5]), .in6(regs[6]), .in7(regs[7]),
        .in8(regs[8]), .in9(regs[9]), .in10(regs[10]), .in11(regs[11]),
        .in12(regs[12]), .in13(regs[13]), .in14(regs[14]), .in15(regs[15]),
        .y(m1)
    );

    // forwarding is gated by rst_n so outputs read zero throughout reset
    assign wr_ok  = BYPASS && rst_n && we && waddr != REG_ZERO;
    assign hit0   = wr_ok && waddr == raddr0;
    assign hit1   = wr_ok && waddr == raddr1;
    assign rdata0 = hit0 ? wdata : m0;
    assign rdata1 = hit1 ? wdata : m1;
    assign rbusy0 = busy_vec[raddr0] && !(hit0 && !(iss && issue_rd == raddr0));
    assign rbusy1 = busy_vec[raddr1] && !(hit1 && !(iss && issue_rd == raddr1));
endmodule

// File: tb/tb_rf16_sb.sv
// tb_rf16_sb: table-driven scoreboard bench for rf16_sb
module tb_rf16_sb;
    logic        clk = 0;
    logic        rst_n;
    logic [3:0]  raddr0, raddr1, waddr, issue_rd;
    logic [31:0] rdata0, rdata1, rdata0_nb, rdata1_nb, wdata;
    logic        rbusy0, rbusy1, rbusy0_nb, rbusy1_nb, we, iss;
    logic [15:0] busy_vec, busy_vec_nb;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic        iss;
        logic [3:0]  rd;
        logic [3:0]  r0, r1;
        logic [31:0] e0, e1;
        logic        eb0, eb1;
        logic [15:0] ev;
    } vec_t;

    typedef struct {
        logic [31:0] d0, d1;
        logic        b0, b1;
        logic [15:0] bv;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[17];

    rf16_sb #(.DATA_WIDTH(32), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .raddr0(raddr0), .rdata0(rdata0), .rbusy0(rbusy0),
        .raddr1(raddr1), .rdata1(rdata1), .rbusy1(rbusy1), .we(we), .waddr(waddr),
        .wdata(wdata), .iss(iss), .issue_rd(issue_rd), .busy_vec(busy_vec)
    );

    rf16_sb #(.DATA_WIDTH(32), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .raddr0(raddr0), .rdata0(rdata0_nb), .rbusy0(rbusy0_nb),
        .raddr1(raddr1), .rdata1(rdata1_nb), .rbusy1(rbusy1_nb), .we(we), .waddr(waddr),
        .wdata(wdata), .iss(iss), .issue_rd(issue_rd), .busy_vec(busy_vec_nb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    // drive one cycle at posedge+1, compare at negedge, return at next posedge+1
    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        we = v.we; waddr = v.waddr; wdata = v.wdata;
        iss = v.iss; issue_rd = v.rd; raddr0 = v.r0; raddr1 = v.r1;
        exp_q.push_back('{v.e0, v.e1, v.eb0, v.eb1, v.ev});
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, " rdata0"}, 64'(rdata0), 64'(e.d0));
        chk({tag, " rdata1"}, 64'(rdata1), 64'(e.d1));
        chk({tag, " rbusy0"}, 64'(rbusy0), 64'(e.b0));
        chk({tag, " rbusy1"}, 64'(rbusy1), 64'(e.b1));
        chk({tag, " busy_vec"}, 64'(busy_vec), 64'(e.bv));
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic w, logic [3:0] wa, logic [31:0] wd, logic is, logic [3:0] rd,
                                logic [3:0] r0, logic [3:0] r1, logic [31:0] e0, logic [31:0] e1,
                                logic eb0, logic eb1, logic [15:0] ev);
        vec_t v;
        v = '{w, wa, wd, is, rd, r0, r1, e0, e1, eb0, eb1, ev};
        return v;
    endfunction

    initial begin
        rst_n = 0; we = 0; waddr = 0; wdata = 0; iss = 0; issue_rd = 0; raddr0 = 0; raddr1 = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < 16; r++)
            apply($sformatf("rst r%0d", r), mk(0, 0, 0, 0, 0, 4'(r), 4'(r), 0, 0, 0, 0, 16'h0000));
        rst_n = 1;

        for (int n = 1; n < 16; n++)
            apply($sformatf("wr%0d", n), mk(1, 4'(n), 32'(n) * 32'h1111, 0, 0, 4'(n), 0,
                                            32'(n) * 32'h1111, 0, 0, 0, 16'h0000));
        apply("wr0", mk(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
        for (int r = 0; r < 16; r++)
            apply($sformatf("sweep r%0d", r), mk(0, 0, 0, 0, 0, 4'(r), 4'(15 - r),
                  32'(r) * 32'h1111, 32'(15 - r) * 32'h1111, 0, 0, 16'h0000));

        we = 1; waddr = 5; wdata = 32'hA5A5_0001; iss = 0; raddr0 = 5; raddr1 = 5;
        @(negedge clk);
        chk("byp rdata0", 64'(rdata0), 64'h0000_0000_A5A5_0001);
        chk("byp rdata1", 64'(rdata1), 64'h0000_0000_A5A5_0001);
        chk("nobyp rdata0 old", 64'(rdata0_nb), 64'h5555);
        @(posedge clk);
        #1;
        we = 0;
        @(negedge clk);
        chk("byp rdata0 after", 64'(rdata0), 64'hA5A5_0001);
        chk("nobyp rdata0 after", 64'(rdata0_nb), 64'hA5A5_0001);
        @(posedge clk);
        #1;

        tbl[0]  = mk(0, 0, 0, 1, 7, 0, 7, 0, 32'h7777, 0, 0, 16'h0000);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 7, 0, 32'h7777, 0, 1, 16'h0080);
        tbl[2]  = mk(1, 7, 32'h7070, 0, 0, 7, 7, 32'h7070, 32'h7070, 0, 0, 16'h0080);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 7, 0, 32'h7070, 0, 0, 16'h0000);
        tbl[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        tbl[6]  = mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 16'h0000);
        tbl[7]  = mk(0, 0, 0, 0, 0, 3, 0, 32'h3333, 0, 1, 0, 16'h0008);
        tbl[8]  = mk(1, 3, 32'hC3C3, 1, 3, 3, 0, 32'hC3C3, 0, 1, 0, 16'h0008);
        tbl[9]  = mk(0, 0, 0, 0, 0, 3, 0, 32'hC3C3, 0, 1, 0, 16'h0008);
        tbl[10] = mk(1, 3, 32'h33, 1, 9, 3, 9, 32'h33, 32'h9999, 0, 0, 16'h0008);
        tbl[11] = mk(0, 0, 0, 0, 0, 3, 9, 32'h33, 32'h9999, 0, 1, 16'h0200);
        tbl[12] = mk(1, 9, 32'h99, 1, 4, 0, 9, 0, 32'h99, 0, 0, 16'h0200);
        tbl[13] = mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 16'h0010);
        tbl[14] = mk(0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 16'h0030);
        tbl[15] = mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 16'h0070);
        tbl[16] = mk(0, 0, 0, 0, 0, 4, 7, 32'h4444, 32'h7070, 1, 1, 16'h00F0);
        for (int i = 0; i < 17; i++) apply($sformatf("v%0d", i), tbl[i]);

        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("async rdata0", 64'(rdata0), 64'h0);
        chk("async rdata1", 64'(rdata1), 64'h0);
        chk("async rbusy0", 64'(rbusy0), 64'h0);
        chk("async rbusy1", 64'(rbusy1), 64'h0);
        chk("async busy_vec", 64'(busy_vec), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1;
        apply("post wr4", mk(1, 4, 32'h1234, 0, 0, 4, 7, 32'h1234, 0, 0, 0, 16'h0000));
        apply("post rd4", mk(0, 0, 0, 0, 0, 4, 7, 32'h1234, 0, 0, 0, 16'h0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf16_sb.md
Name: rf16_sb

Overview:
- 16-entry integer register file with per-register busy scoreboard, sized for the RV32E register set of the MCU core.
- Sits directly upstream of the 16:1 data mux. The 16 register outputs drive the mux data inputs, and the decode-stage source index drives the mux select.
- Provides two read ports, one writeback port and one issue port. The issue port marks a destination as pending until its writeback lands.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports. Must also work at 64.
- BYPASS, 1, when 1, a same-cycle writeback is forwarded to the read ports. When 0, reads return the stored value.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raddr0  in  4  read port 0 register index.
- rdata0  out  DATA_WIDTH  read port 0 data.
- rbusy0  out  1  register at raddr0 has a pending write.
- raddr1  in  4  read port 1 register index.
- rdata1  out  DATA_WIDTH  read port 1 data.
- rbusy1  out  1  register at raddr1 has a pending write.
- we  in  1  writeback enable.
- waddr  in  4  writeback register index.
- wdata  in  DATA_WIDTH  writeback data.
- iss  in  1  issue strobe; marks issue_rd busy.
- issue_rd  in  4  destination index of the issuing instruction.
- busy_vec  out  16  current scoreboard, bit n for register n.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all 16 registers clear to 0; busy_vec = 16'h0000.
  - rdata0/rdata1 read 0; rbusy0/rbusy1 read 0.
  - State stays held while rst_n is low.
  - Deassertion is sampled at the next clk edge, so the first write can land on the first edge after rst_n rises.
- Register 0:
  - reads always return 0 and busy bit 0 is always 0.
  - a write with waddr=0 is discarded; iss with issue_rd=0 is ignored.
- Write:
  - if we=1 and waddr!=0, regs[waddr] <= wdata on the rising edge (1-cycle write latency).
  - the same edge clears busy[waddr].
- Read:
  - combinational, 0-cycle latency; rdataN = regs[raddrN], selected through the 16:1 mux.
  - rbusyN = busy[raddrN], combinational.
- Bypass (BYPASS=1):
  - if we=1, waddr!=0 and waddr==raddrN, then rdataN = wdata in the same cycle, and rbusyN = 0 unless the override below applies.
  - With BYPASS=0, rdataN = the stored value and rbusyN = busy[raddrN].
- Issue: if iss=1 and issue_rd!=0, busy[issue_rd] <= 1 on the rising edge.
- Simultaneous events:
  - we and iss to the same nonzero index in one cycle: the data is written AND busy ends set (issue wins, since it is a newer producer).
  - rbusyN for that index in that cycle reflects the pre-edge busy bit, overridden to 0 by the bypass rule only if BYPASS=1 and no issue to the same index.
  - both read ports may address the same register; they return identical values.
  - we and iss to different indices update independently in the same edge.
- Arithmetic: no arithmetic; indices are 4-bit so there are no out-of-range conditions.
- Reset mid-operation: any pending busy bits and register contents are lost; the writeback arriving after reset is applied normally (clears an already-clear bit).
- No X propagation: all outputs are defined after reset for all input values.

Decomposition:
- Shared package core_pkg:
  - REG_IDX_W = 4, NUM_REGS = 16, REG_ZERO = 4'd0.
  - typedef reg_idx_t (4-bit).
- Sub-module: reuse the existing mux16 (DATA_WIDTH passed through), instantiated once per read port (two instances). Input in0 is tied to 0 so that register 0 reads zero.
- Bypass and busy selection stay in rf16_sb.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> every raddr0 0..15 reads 0, busy_vec=16'h0000.
- Write/read sweep:
  - write regs n=1..15 with n*16'h1111, then sweep raddr0 and raddr1 over 0..15.
  - Required: rdata equals the written values, reg0 reads 0, and a write of 32'hDEAD to index 0 leaves reg0 = 0.
- Bypass (BYPASS=1): we=1, waddr=5, wdata=32'hA5A5_0001 with raddr0=5 in the same cycle -> rdata0=32'hA5A5_0001 before the edge. With BYPASS=0, rdata0 shows the old value until the next cycle.
- Scoreboard:
  - iss with issue_rd=7 -> busy_vec=16'h0080 and rbusy1=1 at raddr1=7.
  - a later we to waddr=7 -> busy_vec=16'h0000.
  - iss with issue_rd=0 -> busy_vec remains 0.
- Simultaneous: busy[3]=1, then we=1/waddr=3 and iss=1/issue_rd=3 on the same edge -> regs[3] updated and busy_vec[3]=1.
- Async reset mid-operation: regs loaded and busy_vec=16'h00F0, then rst_n dropped between clock edges -> outputs 0 immediately, before any clk edge; after release, a write to register 4 succeeds on the first edge.
